dmem_load_responder: RTL and testbench

- Responder end of the load-FU to data-memory request/response interface.
- Accepts one load request per handshake and performs a byte-addressed, little-endian read of a word array after a fixed, parameterised latency.
- Returns sign- or zero-extended data with a one-cycle valid pulse to the requesting load FU.
- Also exposes a byte-strobed write port, used for committed stores and for bench initialisation.

---
 rtl/dmem_load_responder.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_load_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_load_responder.sv
// dmem_load_responder
//   Responder side of the load-FU / data-memory interface. Accepts one load
//   request per handshake and returns a little-endian, sign- or zero-extended
//   result LATENCY cycles later as a one-cycle valid pulse. A byte-strobed
//   write port updates the word array independently of the request FSM.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   issued      request strobe from the load FU
//   addr        request byte address
//   Opcode      instruction opcode (only 7'b0000011 is a legal request)
//   func3       load width / sign select
//   flush       kills an in-flight request (mispredict)
//   ready       a request can be accepted this cycle
//   data_out    extended load result (held between responses)
//   valid       one-cycle response pulse
//   fault       out-of-range address or illegal func3 (valid cycles only)
//   misaligned  halfword/word access not naturally aligned (valid cycles only)
//   wr_en       write-port enable
//   wr_addr     write-port byte address, bits [1:0] ignored
//   wr_data     write data
//   wr_strb     byte enables, bit i writes byte i
module dmem_load_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issued,
  input  logic [31:0] addr,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  func3,
  input  logic        flush,
  output logic        ready,
  output logic [31:0] data_out,
  output logic        valid,
  output logic        fault,
  output logic        misaligned,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb
);

  localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W      = $clog2(LATENCY + 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [6:0]  OP_LOAD    = 7'b0000011;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        addr_reg;
  logic [2:0]         func3_reg;
  logic [1:0]         off_reg;
  logic [2:0]         rfunc3_reg;
  logic               fault_reg, mis_reg;
  logic [31:0]        hold_reg;

  logic               accept, enter_resp;
  logic [31:0]        src_addr;
  logic [2:0]         src_func3;
  logic               f3_legal, out_of_range, src_fault, src_mis, rd_en;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic               wr_in_range;
  logic [31:0]        rd_word;
  logic [31:0]        resp_data;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  assign accept     = issued & ready & (Opcode == OP_LOAD) & ~flush;
  assign enter_resp = (state_next == RESP);

  // With LATENCY=1 the array is read on the accept edge itself, before the
  // request registers hold the address, so the live inputs are used then.
  assign src_addr  = accept ? addr  : addr_reg;
  assign src_func3 = accept ? func3 : func3_reg;

  always_comb begin
    f3_legal = 1'b0;
    case (src_func3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
  end

  // x01 covers exactly LH/LHU; illegal encodings never flag misalignment.
  assign src_mis      = ((src_func3[1:0] == 2'b01) && src_addr[0]) ||
                        ((src_func3 == 3'b010) && (src_addr[1:0] != 2'b00));
  assign out_of_range = (src_addr >= ADDR_LIMIT);
  assign src_fault    = ~f3_legal | out_of_range;
  assign rd_en        = enter_resp & ~src_fault & ~src_mis;
  assign rd_idx       = src_addr[IDX_W+1:2];
  assign wr_idx       = wr_addr[IDX_W+1:2];
  assign wr_in_range  = (wr_addr < ADDR_LIMIT);

  // One byte lane per array so each strobe maps onto its own RAM; the
  // registered read returns pre-write contents when both hit one address.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wr_in_range && wr_strb[gi]) begin
        lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      end
      if (rd_en) begin
        rd_byte_reg <= lane_mem[rd_idx];
      end
    end

    assign rd_word[gi*8 +: 8] = rd_byte_reg;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(1)) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request and response datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg   <= '0;
      func3_reg  <= '0;
      off_reg    <= '0;
      rfunc3_reg <= '0;
      fault_reg  <= 1'b0;
      mis_reg    <= 1'b0;
      hold_reg   <= '0;
    end else begin
      if (accept) begin
        addr_reg  <= addr;
        func3_reg <= func3;
      end
      if (enter_resp) begin
        off_reg    <= src_addr[1:0];
        rfunc3_reg <= src_func3;
        fault_reg  <= src_fault;
        mis_reg    <= src_mis;
      end
      if (state_reg == RESP) begin
        hold_reg <= data_out;
      end
    end
  end

  // Lane selection and extension of the registered word
  always_comb begin
    byte_sel  = rd_word[{off_reg, 3'b000} +: 8];
    half_sel  = off_reg[1] ? rd_word[31:16] : rd_word[15:0];
    resp_data = '0;
    case (rfunc3_reg)
      3'b000:  resp_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  resp_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  resp_data = rd_word;
      3'b100:  resp_data = {24'b0, byte_sel};
      3'b101:  resp_data = {16'b0, half_sel};
      default: resp_data = '0;
    endcase
    if (fault_reg || mis_reg) begin
      resp_data = '0;
    end
  end

  // Outputs
  always_comb begin
    ready      = (state_reg != WAIT);
    valid      = (state_reg == RESP);
    fault      = valid & fault_reg;
    misaligned = valid & mis_reg;
    data_out   = valid ? resp_data : hold_reg;
  end

endmodule

// File: tb/tb_dmem_load_responder.sv
// tb_dmem_load_responder
//   Scoreboard bench: each issued load that should respond pushes its expected
//   cycle, data and flags; a negedge monitor pops and compares on every valid
//   pulse. A second instance with LATENCY=1 shares all inputs.
module tb_dmem_load_responder;

  localparam int         DEPTH   = 256;
  localparam int         LAT     = 2;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issued = 1'b0;
  logic [31:0] addr = '0;
  logic [6:0]  Opcode = '0;
  logic [2:0]  func3 = '0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;

  logic        ready, valid, fault, misaligned;
  logic [31:0] data_out;
  logic        ready_1, valid_1, fault_1, misaligned_1;
  logic [31:0] data_out_1;

  dmem_load_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .issued(issued), .addr(addr), .Opcode(Opcode),
    .func3(func3), .flush(flush), .ready(ready), .data_out(data_out),
    .valid(valid), .fault(fault), .misaligned(misaligned), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  dmem_load_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_1 (
    .clk(clk), .reset(reset), .issued(issued), .addr(addr), .Opcode(Opcode),
    .func3(func3), .flush(flush), .ready(ready_1), .data_out(data_out_1),
    .valid(valid_1), .fault(fault_1), .misaligned(misaligned_1), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        fault;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'b0, valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("resp cyc=%0d data=0x%08h fault=%0b mis=%0b", cyc, data_out, fault, misaligned);
        check("resp_cycle", cyc, mon_e.cyc);
        check("resp_data", data_out, mon_e.data);
        check("resp_fault", {31'b0, fault}, {31'b0, mon_e.fault});
        check("resp_misaligned", {31'b0, misaligned}, {31'b0, mon_e.mis});
      end
    end else begin
      if (reset === 1'b1 || reset === 1'b0) begin
        check("idle_flags", {30'b0, fault, misaligned}, 32'd0);
      end
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        check("valid_missing", {31'b0, valid}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
    $display("write addr=0x%08h data=0x%08h strb=%b", a, d, s);
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] f3, input logic [6:0] op,
                       input bit expect_resp, input logic [31:0] d, input bit fl, input bit ms);
    issued = 1'b1; addr = a; func3 = f3; Opcode = op;
    if (expect_resp) sb.push_back('{cyc + LAT, d, fl, ms});
    $display("issue cyc=%0d addr=0x%08h func3=%03b op=%07b expect=%0b", cyc, a, f3, op, expect_resp);
    tick();
    issued = 1'b0; Opcode = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_data", data_out, 32'd0);
    check("reset_ready", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Array setup
    wr(32'h10, 32'h8081_7F80, 4'hF);
    wr(32'h14, 32'h1122_3344, 4'hF);
    wr(32'h3FC, 32'hA5B6_C7D8, 4'hF);

    // Widths, signs and lanes
    issue(32'h10, 3'b010, OP_LOAD, 1, 32'h8081_7F80, 0, 0); tick(3);
    issue(32'h10, 3'b000, OP_LOAD, 1, 32'hFFFF_FF80, 0, 0); tick(3);
    issue(32'h10, 3'b100, OP_LOAD, 1, 32'h0000_0080, 0, 0); tick(3);
    issue(32'h12, 3'b001, OP_LOAD, 1, 32'hFFFF_8081, 0, 0); tick(3);
    issue(32'h12, 3'b101, OP_LOAD, 1, 32'h0000_8081, 0, 0); tick(3);
    check("hold_data", data_out, 32'h0000_8081);
    issue(32'h3FF, 3'b000, OP_LOAD, 1, 32'hFFFF_FFA5, 0, 0); tick(3);
    issue(32'h3FF, 3'b100, OP_LOAD, 1, 32'h0000_00A5, 0, 0); tick(3);
    issue(32'h3FE, 3'b001, OP_LOAD, 1, 32'hFFFF_A5B6, 0, 0); tick(3);

    // Misalignment, range and illegal func3
    issue(32'h11, 3'b001, OP_LOAD, 1, 32'h0, 0, 1); tick(3);
    issue(32'h12, 3'b010, OP_LOAD, 1, 32'h0, 0, 1); tick(3);
    issue(32'h400, 3'b010, OP_LOAD, 1, 32'h0, 1, 0); tick(3);
    issue(32'h10, 3'b011, OP_LOAD, 1, 32'h0, 1, 0); tick(3);
    issue(32'h402, 3'b010, OP_LOAD, 1, 32'h0, 1, 1); tick(3);

    // Flush in WAIT kills the request
    issue(32'h10, 3'b010, OP_LOAD, 0, 32'h0, 0, 0);
    check("ready_in_wait", {31'b0, ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ready_after_flush", {31'b0, ready}, 32'd1);
    tick(3);

    // Issue while in WAIT is ignored
    issue(32'h10, 3'b010, OP_LOAD, 1, 32'h8081_7F80, 0, 0);
    issue(32'h14, 3'b100, OP_LOAD, 0, 32'h0, 0, 0);
    tick(3);

    // Non-load opcode gets no response
    issue(32'h10, 3'b010, OP_STORE, 0, 32'h0, 0, 0);
    tick(3);

    // Flush in RESP: response still delivered, concurrent issue dropped
    issue(32'h10, 3'b000, OP_LOAD, 1, 32'hFFFF_FF80, 0, 0);
    tick();
    issued = 1'b1; flush = 1'b1; addr = 32'h14; func3 = 3'b010; Opcode = OP_LOAD;
    tick();
    issued = 1'b0; flush = 1'b0; Opcode = '0;
    tick(3);

    // Back-to-back with a write to B's word during A's WAIT
    issue(32'h10, 3'b010, OP_LOAD, 1, 32'h8081_7F80, 0, 0);
    wr(32'h14, 32'hCAFE_BABE, 4'hF);
    issue(32'h14, 3'b010, OP_LOAD, 1, 32'hCAFE_BABE, 0, 0);
    // Lands on the edge that reads B's word: read must see the old data
    wr(32'h14, 32'h0BAD_F00D, 4'b0011);
    tick(3);
    issue(32'h14, 3'b010, OP_LOAD, 1, 32'hCAFE_F00D, 0, 0); tick(3);
    issue(32'h16, 3'b001, OP_LOAD, 1, 32'hFFFF_CAFE, 0, 0); tick(3);

    // Reset during WAIT drops the request
    issue(32'h10, 3'b010, OP_LOAD, 0, 32'h0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("rst_wait_valid", {31'b0, valid}, 32'd0);
    check("rst_wait_ready", {31'b0, ready}, 32'd1);
    check("rst_wait_data", data_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick(4);

    // LATENCY=1 instance responds on the cycle after acceptance
    issue(32'h10, 3'b010, OP_LOAD, 1, 32'h8081_7F80, 0, 0);
    check("l1_valid", {31'b0, valid_1}, 32'd1);
    check("l1_data", data_out_1, 32'h8081_7F80);
    check("l1_flags", {30'b0, fault_1, misaligned_1}, 32'd0);
    tick();
    check("l1_pulse_end", {31'b0, valid_1}, 32'd0);
    check("l1_hold", data_out_1, 32'h8081_7F80);
    tick(4);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
